// File: rtl/quad_encoder_decoder.sv
// quad_encoder_decoder
//
// Quadrature rotary-encoder decoder. The A/B contacts are synchronised and
// glitch-filtered. Gray-code transitions are then decoded at x1, x2 or x4
// resolution into a position counter that either wraps or saturates.
//
// Parameters:
//   CNT_W    - position counter width (>= 2)
//   FILT_LEN - consecutive mismatching cycles before a filtered bit follows (1..255)
//   SATURATE - 0 = wrap modulo 2^CNT_W, 1 = clamp at 0 and 2^CNT_W-1
//
// Ports:
//   clk      - system clock
//   reset    - synchronous active-high reset
//   A, B     - raw encoder channels, asynchronous to clk
//   mode     - resolution: 00 = x1, 01 = x2, 10/11 = x4
//   load     - preset strobe; loads load_val and clears err
//   load_val - preset value
//   count    - position
//   step     - one-cycle pulse per counted edge
//   dir      - direction of last counted edge, 1 = up
//   err      - sticky illegal-transition flag
module quad_encoder_decoder #(
    parameter int CNT_W    = 10,
    parameter int FILT_LEN = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A,
    input  logic             B,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             step,
    output logic             dir,
    output logic             err
);

    localparam logic [7:0]       FILT_LAST = 8'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    logic       aS1, aS2, bS1, bS2;
    logic       aFilt, bFilt, aPrev, bPrev;
    logic [7:0] aCnt, bCnt;
    logic [1:0] primeCnt;

    logic       aFiltNext, bFiltNext;
    logic [7:0] aCntNext, bCntNext;
    logic       priming, changeA, changeB, illegal, qualify, countEdge, goUp;
    logic [CNT_W-1:0] countNext;

    // Per-channel filter: count consecutive cycles where the synchronised
    // bit disagrees with the filtered bit; follow on the FILT_LEN-th one.
    always_comb begin
        aFiltNext = aFilt;
        aCntNext  = 8'd0;
        if (aS2 != aFilt) begin
            if (aCnt == FILT_LAST) begin
                aFiltNext = aS2;
            end else begin
                aCntNext = aCnt + 8'd1;
            end
        end
        bFiltNext = bFilt;
        bCntNext  = 8'd0;
        if (bS2 != bFilt) begin
            if (bCnt == FILT_LAST) begin
                bFiltNext = bS2;
            end else begin
                bCntNext = bCnt + 8'd1;
            end
        end
    end

    // Decoder. In the up sequence 00->01->11->10->00 the new B always
    // differs from the old A, so one XOR gives direction for legal moves.
    always_comb begin
        priming = (primeCnt != 2'd3);
        changeA = aFilt ^ aPrev;
        changeB = bFilt ^ bPrev;
        goUp    = aPrev ^ bFilt;
        illegal = changeA & changeB & ~priming;
        case (mode)
            2'b00:   qualify = changeA & aFilt;
            2'b01:   qualify = changeA;
            default: qualify = 1'b1;
        endcase
        countEdge = (changeA ^ changeB) & qualify & ~priming;
        countNext = count;
        if (goUp) begin
            if (!(SATURATE != 0 && count == CNT_MAX)) begin
                countNext = count + CNT_ONE;
            end
        end else begin
            if (!(SATURATE != 0 && count == CNT_ZERO)) begin
                countNext = count - CNT_ONE;
            end
        end
    end

    // During the first three edges after reset the filter and previous
    // state track s2 directly, so an encoder resting at 11 does not look
    // like a transition out of the cleared 00 state.
    always_ff @(posedge clk) begin
        if (reset) begin
            aS1      <= 1'b0;
            aS2      <= 1'b0;
            bS1      <= 1'b0;
            bS2      <= 1'b0;
            aFilt    <= 1'b0;
            bFilt    <= 1'b0;
            aPrev    <= 1'b0;
            bPrev    <= 1'b0;
            aCnt     <= 8'd0;
            bCnt     <= 8'd0;
            primeCnt <= 2'd0;
        end else begin
            aS1 <= A;
            aS2 <= aS1;
            bS1 <= B;
            bS2 <= bS1;
            if (priming) begin
                aFilt    <= aS2;
                bFilt    <= bS2;
                aPrev    <= aS2;
                bPrev    <= bS2;
                aCnt     <= 8'd0;
                bCnt     <= 8'd0;
                primeCnt <= primeCnt + 2'd1;
            end else begin
                aFilt <= aFiltNext;
                bFilt <= bFiltNext;
                aCnt  <= aCntNext;
                bCnt  <= bCntNext;
                aPrev <= aFilt;
                bPrev <= bFilt;
            end
        end
    end

    // Outputs. A load wins over a same-cycle edge, which is dropped
    // silently; dir keeps the direction of the last edge actually counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            step  <= 1'b0;
            dir   <= 1'b0;
            err   <= 1'b0;
        end else if (load) begin
            count <= load_val;
            step  <= 1'b0;
            err   <= 1'b0;
        end else begin
            step <= countEdge;
            if (countEdge) begin
                count <= countNext;
                dir   <= goUp;
            end
            if (illegal) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Testbench for quad_encoder_decoder. Two instances share all inputs: one
// wrapping (dutM) and one saturating (dutS). Expected step results are
// queued per instance and popped by monitors whenever step is seen.
module tb_quad_encoder_decoder;

    logic       clk;
    logic       reset;
    logic       A, B;
    logic [1:0] mode;
    logic       load;
    logic [9:0] load_val;
    logic [9:0] countM, countS;
    logic       stepM, stepS, dirM, dirS, errM, errS;

    typedef struct {
        logic [9:0] cnt;
        logic       d;
    } expT;

    expT expQM[$];
    expT expQS[$];

    int errors = 0;
    int checks = 0;

    quad_encoder_decoder #(.CNT_W(10), .FILT_LEN(4), .SATURATE(0)) dutM (
        .clk(clk), .reset(reset), .A(A), .B(B), .mode(mode),
        .load(load), .load_val(load_val),
        .count(countM), .step(stepM), .dir(dirM), .err(errM)
    );

    quad_encoder_decoder #(.CNT_W(10), .FILT_LEN(4), .SATURATE(1)) dutS (
        .clk(clk), .reset(reset), .A(A), .B(B), .mode(mode),
        .load(load), .load_val(load_val),
        .count(countS), .step(stepS), .dir(dirS), .err(errS)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor for the wrapping instance: every step pulse must match the
    // next queued expectation.
    always @(negedge clk) begin
        if (stepM === 1'b1) begin
            checks++;
            if (expQM.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedStepM: count=%0d dir=%0d, no step was required", countM, dirM);
            end else begin
                expT e;
                e = expQM.pop_front();
                if (countM !== e.cnt || dirM !== e.d) begin
                    errors++;
                    $display("[TB] FAIL stepM: count=%0d dir=%0d, required count=%0d dir=%0d", countM, dirM, e.cnt, e.d);
                end
            end
        end
    end

    // Monitor for the saturating instance.
    always @(negedge clk) begin
        if (stepS === 1'b1) begin
            checks++;
            if (expQS.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedStepS: count=%0d dir=%0d, no step was required", countS, dirS);
            end else begin
                expT e;
                e = expQS.pop_front();
                if (countS !== e.cnt || dirS !== e.d) begin
                    errors++;
                    $display("[TB] FAIL stepS: count=%0d dir=%0d, required count=%0d dir=%0d", countS, dirS, e.cnt, e.d);
                end
            end
        end
    end

    task automatic expectStep(input logic [9:0] cM, input logic [9:0] cS, input logic d);
        expT e;
        e.cnt = cM;
        e.d   = d;
        expQM.push_back(e);
        e.cnt = cS;
        expQS.push_back(e);
    endtask

    task automatic checkOne(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic checkOutput(input string name, input int cM, input int cS,
                               input int d, input int e);
        checkOne({name, ".countM"}, int'(countM), cM);
        checkOne({name, ".countS"}, int'(countS), cS);
        checkOne({name, ".dirM"}, int'(dirM), d);
        checkOne({name, ".dirS"}, int'(dirS), d);
        checkOne({name, ".errM"}, int'(errM), e);
        checkOne({name, ".errS"}, int'(errS), e);
    endtask

    // Drive a new A/B pair at the current negedge and hold it.
    task automatic applyStimulus(input logic a, input logic b, input int hold);
        A = a;
        B = b;
        repeat (hold) @(negedge clk);
    endtask

    task automatic doLoad(input logic [9:0] v);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        A        = 1'b1;
        B        = 1'b1;
        mode     = 2'b10;
        load     = 1'b0;
        load_val = 10'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset", 0, 0, 0, 0);

        // Encoder resting at 11 through priming: nothing counted.
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("priming", 0, 0, 0, 0);

        // x4: 11 -> 10 -> 00, both up moves.
        expectStep(10'd1, 10'd1, 1'b1);
        applyStimulus(1'b1, 1'b0, 10);
        expectStep(10'd2, 10'd2, 1'b1);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("x4pre", 2, 2, 1, 0);
        doLoad(10'd0);
        checkOutput("load0", 0, 0, 1, 0);

        // x4 full up cycle with latency check on the first B change.
        expectStep(10'd1, 10'd1, 1'b1);
        A = 1'b0;
        B = 1'b1;
        repeat (6) @(negedge clk);
        checkOne("latencyEarly", int'(stepM), 0);
        @(negedge clk);
        checkOne("latency", int'(stepM), 1);
        repeat (3) @(negedge clk);
        expectStep(10'd2, 10'd2, 1'b1);
        applyStimulus(1'b1, 1'b1, 10);
        expectStep(10'd3, 10'd3, 1'b1);
        applyStimulus(1'b1, 1'b0, 10);
        expectStep(10'd4, 10'd4, 1'b1);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("x4cycle", 4, 4, 1, 0);

        // x2 full up cycle: only A edges count.
        doLoad(10'd0);
        mode = 2'b01;
        applyStimulus(1'b0, 1'b1, 10);
        expectStep(10'd1, 10'd1, 1'b1);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
        expectStep(10'd2, 10'd2, 1'b1);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("x2cycle", 2, 2, 1, 0);

        // x1 full up cycle: only A rising counts.
        doLoad(10'd0);
        mode = 2'b00;
        applyStimulus(1'b0, 1'b1, 10);
        expectStep(10'd1, 10'd1, 1'b1);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("x1cycle", 1, 1, 1, 0);

        // x1 reverse cycle from 5: A rises with B=0, one down count.
        doLoad(10'd5);
        expectStep(10'd4, 10'd4, 1'b0);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("x1rev", 4, 4, 0, 0);

        // Boundaries: wrap vs saturate at the top, then at the bottom.
        mode = 2'b10;
        doLoad(10'd1023);
        expectStep(10'd0, 10'd1023, 1'b1);
        applyStimulus(1'b0, 1'b1, 10);
        checkOutput("topEdge", 0, 1023, 1, 0);
        doLoad(10'd0);
        expectStep(10'd1023, 10'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("bottomEdge", 1023, 0, 0, 0);

        // 3-cycle glitch on A must be swallowed by the filter.
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 12);
        checkOutput("glitch", 1023, 0, 0, 0);

        // Both channels flip together: illegal, err set, no count.
        applyStimulus(1'b1, 1'b1, 12);
        checkOutput("illegal", 1023, 0, 0, 1);
        doLoad(10'd37);
        checkOutput("loadClrErr", 37, 37, 0, 0);

        // Load on the very edge that would count 11 -> 10: edge dropped.
        A = 1'b1;
        B = 1'b0;
        repeat (6) @(negedge clk);
        load     = 1'b1;
        load_val = 10'd100;
        @(negedge clk);
        load = 1'b0;
        checkOutput("loadPriority", 100, 100, 0, 0);
        repeat (8) @(negedge clk);
        checkOutput("loadPriorityAfter", 100, 100, 0, 0);

        // Reset in the middle of a filter count.
        A = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midReset", 0, 0, 0, 0);
        checkOne("midResetStep", int'(stepM), 0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("afterReset", 0, 0, 0, 0);

        checkOne("pendingStepsM", expQM.size(), 0);
        checkOne("pendingStepsS", expQS.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quad_encoder_decoder.md
# quad_encoder_decoder

Parametrised quadrature rotary-encoder decoder for the expansion-board demos. Synchronises and glitch-filters the A/B encoder contacts, decodes Gray-code transitions at x1, x2 or x4 resolution into a signed-direction position counter with wrap or saturate arithmetic, preset load, per-step pulse and sticky illegal-transition error. It sits between the board's encoder pins and display or control logic, with `count` consumed directly.

## Interface
- `CNT_W`, 10: position counter width (≥2).
- `FILT_LEN`, 4: consecutive cycles a synchronised input must differ from its filtered value before the filtered value follows (≥1, ≤255).
- `SATURATE`, 0: 0 = counter wraps modulo 2^CNT_W; 1 = clamps at 0 and 2^CNT_W−1.

- `clk` in 1: system clock, single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `A` in 1: encoder channel A, asynchronous to `clk`.
- `B` in 1: encoder channel B, asynchronous to `clk`.
- `mode` in 2: resolution; 00 = x1, 01 = x2, 10/11 = x4.
- `load` in 1: preset strobe.
- `load_val` in CNT_W: preset value.
- `count` out CNT_W: position.
- `step` out 1: one-cycle pulse when `count` changes due to an edge.
- `dir` out 1: direction of last counted edge; 1 = up.
- `err` out 1: sticky illegal-transition flag.

## Operation
- Synchroniser: two flops per input (s1, s2).
- Filter: per channel, a counter of consecutive cycles with s2 ≠ filtered. It clears on match. The filtered bit takes s2 at the edge completing FILT_LEN consecutive mismatches.
- Decoder: compares filtered state {A,B} with the previous filtered state.
  - Up sequence: 00→01→11→10→00. Down is the reverse.
  - Both bits changed: illegal. Set `err`; no count.
- Qualification by `mode`:
  - x4: every legal transition counts.
  - x2: only transitions where A changes count.
  - x1: only A rising counts. Up if B=1, down if B=0.
- Arithmetic:
  - SATURATE=0: ±1 modulo 2^CNT_W. Max+1 gives 0; 0−1 gives max.
  - SATURATE=1: holds at the limit. `step` and `dir` still update at the limit.
- `load`:
  - `count` takes `load_val` and `err` clears.
  - `load` has priority over a same-cycle edge; that edge is dropped with no `step`.
  - `dir` is unchanged by `load`.
- Priming: for the first 3 edges after `reset` deasserts, filtered and previous registers load s2 directly. No counting and no `err` during priming. This avoids a false edge when the encoder rests at 11.
- `mode` changes take effect on the next edge. `count` is not affected.

## Timing
- Reset values: `count`=0, `step`=0, `dir`=0, `err`=0. Sync, filter, previous-state and priming registers are cleared. Reset mid-operation discards any in-progress filter count.
- Latency: a change on A or B stable before edge N is reflected in `count`/`step`/`dir` after edge N+2+FILT_LEN.
- A pulse shorter than FILT_LEN cycles at s2 never reaches the decoder.
- `step` is high for exactly the cycle following the counting edge. Consecutive edges on consecutive cycles give consecutive `step` cycles.
- `err` is set at the same edge the illegal transition would have counted. It stays set until `reset` or `load`.
- Simultaneous A and B filter completion in one cycle is an illegal transition.

## Test plan
- Reset, then 3 priming edges with A=B=1 held → `count`=0, `err`=0, no `step`.
- x4, FILT_LEN=4, one full up cycle 00→01→11→10→00 with each state held 10 cycles → `count`=4, four `step` pulses, `dir`=1. First `step` appears 7 cycles after the first B change.
- Same sequence in x2 → `count`=2; in x1 → `count`=1. Reverse sequence in x1 from 5 → 4, `dir`=0.
- SATURATE=0, CNT_W=10, `load` 1023, one up step → 0. SATURATE=1: `load` 1023, up step → 1023 with `step` pulsed; `load` 0, down step → 0.
- 3-cycle glitch on A with FILT_LEN=4 → no change. Forced A and B toggle in the same cycle → `err`=1, `count` unchanged. Then `load` 37 → `err`=0, `count`=37.
- `load` asserted on the same cycle as a counting edge → `count`=`load_val`, no `step`. Assert `reset` mid-filter → all outputs 0 next cycle.
